snitch_sb_id_pool: RTL and testbench

Parametrised free-list of scoreboard slot IDs for the Snitch scoreboard. It resets holding every ID `0..NumIds-1` in ascending order and hands them out in FIFO order on up to `NumAlloc` ports per cycle. IDs come back on up to `NumFree` ports per cycle. Binary or one-hot ID encoding is selectable. An in-use bitmap rejects double frees and out-of-range frees, and a synchronous flush returns the pool to its reset contents.

---
 rtl/snitch_sb_id_pool_pkg.sv | 41 ++++
 rtl/snitch_sb_id_pool_if.sv | 34 +++
 rtl/snitch_sb_id_pool_check.sv | 86 ++++++++
 rtl/snitch_sb_id_pool.sv | 138 +++++++++++++
 tb/tb_snitch_sb_id_pool.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/snitch_sb_id_pool_pkg.sv
// Shared types and ID encode/decode helpers for the scoreboard ID pool.
package snitch_sb_pkg;

    // Upper bound on pool size supported by the encode/decode helpers.
    localparam int unsigned SbMaxIds = 64;
    localparam int unsigned SbMaxIdW = 6;

    typedef logic [SbMaxIds-1:0] sb_vec_t;
    typedef logic [SbMaxIdW-1:0] sb_id_t;

    // Encode a binary ID as a one-hot vector; IDs at or above n give all zeros.
    function automatic sb_vec_t sb_id_onehot(input sb_id_t id, input int unsigned n);
        sb_vec_t vec;
        vec = '0;
        if (32'(id) < n) begin
            vec[id] = 1'b1;
        end else begin
            vec = '0;
        end
        return vec;
    endfunction

    // Decode a one-hot vector to binary; ok is set only when exactly one bit is set.
    function automatic sb_id_t sb_id_bin(input sb_vec_t vec, output logic ok);
        sb_id_t      bin;
        int unsigned ones;
        bin  = '0;
        ones = 32'd0;
        for (int unsigned i = 0; i < SbMaxIds; i++) begin
            if (vec[i]) begin
                bin  = sb_id_t'(i);
                ones = ones + 32'd1;
            end else begin
                ones = ones;
            end
        end
        ok = (ones == 32'd1);
        return bin;
    endfunction

endpackage

// File: rtl/snitch_sb_id_pool_if.sv
// Allocation / release handshake bundle of the scoreboard ID pool.
interface snitch_sb_id_pool_if #(
    parameter int unsigned NumIds   = 8,
    parameter int unsigned NumAlloc = 1,
    parameter int unsigned NumFree  = 1,
    parameter int unsigned OneHot   = 0
);
    localparam int unsigned IdW   = $clog2(NumIds);
    localparam int unsigned PortW = (OneHot != 0) ? NumIds : IdW;
    localparam int unsigned CntW  = $clog2(NumIds + 1);

    logic [NumAlloc-1:0]            alloc_valid_o;
    logic [NumAlloc-1:0][PortW-1:0] alloc_id_o;
    logic [NumAlloc-1:0]            alloc_ready_i;
    logic [NumFree-1:0]             free_valid_i;
    logic [NumFree-1:0][PortW-1:0]  free_id_i;
    logic                           free_err_o;
    logic                           empty_o;
    logic                           full_o;
    logic [CntW-1:0]                usage_o;

    // The pool side.
    modport master (
        output alloc_valid_o, alloc_id_o, free_err_o, empty_o, full_o, usage_o,
        input  alloc_ready_i, free_valid_i, free_id_i
    );

    // The consumer side.
    modport slave (
        input  alloc_valid_o, alloc_id_o, free_err_o, empty_o, full_o, usage_o,
        output alloc_ready_i, free_valid_i, free_id_i
    );

endinterface

// File: rtl/snitch_sb_id_pool_check.sv
// Per-port release validation: legality, in-use lookup, duplicate masking
// and compaction of the accepted IDs in port order.
module snitch_sb_id_pool_check
    import snitch_sb_pkg::*;
#(
    parameter int unsigned NumIds  = 8,
    parameter int unsigned NumFree = 1,
    parameter int unsigned OneHot  = 0,
    localparam int unsigned IdW    = $clog2(NumIds),
    localparam int unsigned PortW  = (OneHot != 0) ? NumIds : IdW,
    localparam int unsigned CntW   = $clog2(NumIds + 1)
) (
    input  logic [NumFree-1:0]            free_valid_i,
    input  logic [NumFree-1:0][PortW-1:0] free_id_i,
    input  logic [NumIds-1:0]             inuse_i,
    output logic [NumFree-1:0]            accept_o,
    output logic [NumFree-1:0][IdW-1:0]   ids_o,
    output logic [CntW-1:0]               nfree_o
);

    logic [NumFree-1:0][IdW-1:0] id_bin_s;
    logic [NumFree-1:0]          legal_s;
    logic [NumFree-1:0]          accept_s;
    logic [NumFree-1:0][IdW-1:0] ids_s;
    logic [CntW-1:0]             nfree_s;

    if (OneHot != 0) begin : g_onehot
        // Decode one-hot release IDs; anything but exactly one bit is illegal.
        always_comb begin
            sb_id_t dec_v;
            logic   ok_v;
            dec_v    = '0;
            ok_v     = 1'b0;
            id_bin_s = '0;
            legal_s  = '0;
            for (int unsigned j = 0; j < NumFree; j++) begin
                dec_v       = sb_id_bin(SbMaxIds'(free_id_i[j]), ok_v);
                id_bin_s[j] = dec_v[IdW-1:0];
                legal_s[j]  = ok_v && (32'(dec_v) < NumIds);
            end
        end
    end else begin : g_binary
        // Binary release IDs are legal only below the pool size.
        always_comb begin
            id_bin_s = '0;
            legal_s  = '0;
            for (int unsigned j = 0; j < NumFree; j++) begin
                id_bin_s[j] = free_id_i[j];
                legal_s[j]  = (CntW'(free_id_i[j]) < CntW'(NumIds));
            end
        end
    end

    // Accept legal in-use IDs that no lower port has already claimed this cycle.
    always_comb begin
        logic dup_v;
        dup_v    = 1'b0;
        accept_s = '0;
        for (int unsigned j = 0; j < NumFree; j++) begin
            dup_v = 1'b0;
            for (int unsigned i = 0; i < j; i++) begin
                dup_v = dup_v | (accept_s[i] && (id_bin_s[i] == id_bin_s[j]));
            end
            accept_s[j] = free_valid_i[j] && legal_s[j] && inuse_i[id_bin_s[j]] && !dup_v;
        end
    end

    // Pack accepted IDs densely in port order and count them.
    always_comb begin
        ids_s   = '0;
        nfree_s = {CntW{1'b0}};
        for (int unsigned j = 0; j < NumFree; j++) begin
            if (accept_s[j]) begin
                ids_s[nfree_s] = id_bin_s[j];
                nfree_s        = nfree_s + CntW'(1'b1);
            end else begin
                nfree_s = nfree_s;
            end
        end
    end

    assign accept_o = accept_s;
    assign ids_o    = ids_s;
    assign nfree_o  = nfree_s;

endmodule

// File: rtl/snitch_sb_id_pool.sv
// Scoreboard slot-ID free list: circular buffer of free IDs handed out in
// FIFO order, with an in-use bitmap guarding releases.
module snitch_sb_id_pool
    import snitch_sb_pkg::*;
#(
    parameter int unsigned NumIds   = 8,
    parameter int unsigned NumAlloc = 1,
    parameter int unsigned NumFree  = 1,
    parameter int unsigned OneHot   = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    snitch_sb_id_pool_if.master bus
);

    localparam int unsigned IdW  = $clog2(NumIds);
    localparam int unsigned CntW = $clog2(NumIds + 1);

    logic [NumIds-1:0][IdW-1:0]   mem_r;
    logic [IdW-1:0]               rd_r;
    logic [IdW-1:0]               wr_r;
    logic [CntW-1:0]              cnt_r;
    logic [NumIds-1:0]            inuse_r;
    logic                         free_err_r;

    logic [NumAlloc-1:0]          valid_s;
    logic [NumAlloc-1:0][IdW-1:0] offer_s;
    logic [CntW-1:0]              nalloc_s;
    logic [NumIds-1:0]            set_s;
    logic [NumIds-1:0]            clr_s;
    logic [NumFree-1:0]           accept_s;
    logic [NumFree-1:0][IdW-1:0]  free_ids_s;
    logic [CntW-1:0]              nfree_s;

    // Pointer advance modulo NumIds; works for non-power-of-two pool sizes.
    function automatic logic [IdW-1:0] ptr_add(input logic [IdW-1:0] p, input logic [CntW-1:0] inc);
        logic [CntW:0] sum;
        sum = (CntW+1)'(p) + (CntW+1)'(inc);
        if (sum >= (CntW+1)'(NumIds)) begin
            sum = sum - (CntW+1)'(NumIds);
        end else begin
            sum = sum;
        end
        return sum[IdW-1:0];
    endfunction

    snitch_sb_id_pool_check #(
        .NumIds  (NumIds),
        .NumFree (NumFree),
        .OneHot  (OneHot)
    ) i_check (
        .free_valid_i (bus.free_valid_i),
        .free_id_i    (bus.free_id_i),
        .inuse_i      (inuse_r),
        .accept_o     (accept_s),
        .ids_o        (free_ids_s),
        .nfree_o      (nfree_s)
    );

    // Offer the next NumAlloc IDs from the head of the free list.
    always_comb begin
        valid_s = '0;
        offer_s = '0;
        for (int unsigned k = 0; k < NumAlloc; k++) begin
            valid_s[k] = (cnt_r > CntW'(k));
            offer_s[k] = mem_r[ptr_add(rd_r, CntW'(k))];
        end
    end

    // Prefix-rule allocation: a port transfers only if every lower port does.
    always_comb begin
        logic prefix_v;
        prefix_v = 1'b1;
        nalloc_s = {CntW{1'b0}};
        set_s    = '0;
        for (int unsigned k = 0; k < NumAlloc; k++) begin
            prefix_v          = prefix_v & valid_s[k] & bus.alloc_ready_i[k];
            nalloc_s          = nalloc_s + CntW'(prefix_v);
            set_s[offer_s[k]] = set_s[offer_s[k]] | prefix_v;
        end
    end

    // In-use bits to drop for the IDs accepted back this cycle.
    always_comb begin
        clr_s = '0;
        for (int unsigned j = 0; j < NumFree; j++) begin
            clr_s[free_ids_s[j]] = clr_s[free_ids_s[j]] | (CntW'(j) < nfree_s);
        end
    end

    // Free-list storage, pointers, count, bitmap and the release error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                mem_r[i] <= IdW'(i);
            end
            rd_r       <= {IdW{1'b0}};
            wr_r       <= {IdW{1'b0}};
            cnt_r      <= CntW'(NumIds);
            inuse_r    <= {NumIds{1'b0}};
            free_err_r <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NumFree; j++) begin
                if (CntW'(j) < nfree_s) begin
                    mem_r[ptr_add(wr_r, CntW'(j))] <= free_ids_s[j];
                end
            end
            rd_r       <= ptr_add(rd_r, nalloc_s);
            wr_r       <= ptr_add(wr_r, nfree_s);
            cnt_r      <= cnt_r + nfree_s - nalloc_s;
            inuse_r    <= (inuse_r | set_s) & ~clr_s;
            free_err_r <= |(bus.free_valid_i & ~accept_s);
        end
    end

    if (OneHot != 0) begin : g_out_onehot
        // Present offered IDs as one-hot vectors.
        always_comb begin
            sb_vec_t oh_v;
            oh_v           = '0;
            bus.alloc_id_o = '0;
            for (int unsigned k = 0; k < NumAlloc; k++) begin
                oh_v              = sb_id_onehot(sb_id_t'(offer_s[k]), NumIds);
                bus.alloc_id_o[k] = oh_v[NumIds-1:0];
            end
        end
    end else begin : g_out_binary
        assign bus.alloc_id_o = offer_s;
    end

    assign bus.alloc_valid_o = valid_s;
    assign bus.free_err_o    = free_err_r;
    assign bus.empty_o       = (cnt_r == {CntW{1'b0}});
    assign bus.full_o        = (cnt_r == CntW'(NumIds));
    assign bus.usage_o       = cnt_r;

endmodule

// File: tb/tb_snitch_sb_id_pool.sv
// Self-checking bench for snitch_sb_id_pool: a queue-based reference model
// for the main 8-ID configuration, plus one-hot and 6-ID instances.
module tb_snitch_sb_id_pool;

    logic clk = 1'b0;
    logic rst;
    logic flush_m;
    logic flush_h;
    logic flush_p;

    always #5 clk = ~clk;

    snitch_sb_id_pool_if #(.NumIds(8), .NumAlloc(2), .NumFree(2), .OneHot(0)) bus_m ();
    snitch_sb_id_pool_if #(.NumIds(8), .NumAlloc(2), .NumFree(1), .OneHot(1)) bus_h ();
    snitch_sb_id_pool_if #(.NumIds(6), .NumAlloc(1), .NumFree(1), .OneHot(0)) bus_p ();

    snitch_sb_id_pool #(.NumIds(8), .NumAlloc(2), .NumFree(2), .OneHot(0)) i_dut_m (
        .clk_i (clk), .rst_i (rst), .flush_i (flush_m), .bus (bus_m)
    );
    snitch_sb_id_pool #(.NumIds(8), .NumAlloc(2), .NumFree(1), .OneHot(1)) i_dut_h (
        .clk_i (clk), .rst_i (rst), .flush_i (flush_h), .bus (bus_h)
    );
    snitch_sb_id_pool #(.NumIds(6), .NumAlloc(1), .NumFree(1), .OneHot(0)) i_dut_p (
        .clk_i (clk), .rst_i (rst), .flush_i (flush_p), .bus (bus_p)
    );

    int num_checks = 0;
    int num_errors = 0;

    // Reference model of the main pool: free IDs in FIFO order plus in-use bits.
    int m_q[$];
    bit m_inuse[8];
    bit m_err;
    // Scoreboard of IDs expected to be handed out.
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        m_q = {};
        for (int i = 0; i < 8; i++) begin
            m_q.push_back(i);
            m_inuse[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the main pool: drive, compare against the model, advance the model.
    task automatic step(input logic [1:0] rdy, input logic [1:0] fv, input int f0, input int f1, input logic fl);
        int nal;
        bit acc0;
        bit acc1;
        int x;
        bus_m.alloc_ready_i = rdy;
        bus_m.free_valid_i  = fv;
        bus_m.free_id_i[0]  = 3'(f0);
        bus_m.free_id_i[1]  = 3'(f1);
        flush_m             = fl;
        nal = 0;
        if (!fl) begin
            for (int k = 0; k < 2; k++) begin
                if (nal == k && rdy[k] && m_q.size() > k) nal = k + 1;
            end
        end
        for (int k = 0; k < nal; k++) exp_q.push_back(m_q[k]);
        @(negedge clk);
        chk("usage", 32'(bus_m.usage_o), 32'(m_q.size()));
        chk("empty", 32'(bus_m.empty_o), 32'(m_q.size() == 0));
        chk("full", 32'(bus_m.full_o), 32'(m_q.size() == 8));
        chk("free_err", 32'(bus_m.free_err_o), 32'(m_err));
        for (int k = 0; k < 2; k++) begin
            chk("alloc_valid", 32'(bus_m.alloc_valid_o[k]), 32'(m_q.size() > k));
            if (m_q.size() > k) chk("alloc_id", 32'(bus_m.alloc_id_o[k]), 32'(m_q[k]));
        end
        for (int k = 0; k < nal; k++) begin
            x = exp_q.pop_front();
            chk("alloc_xfer", 32'(bus_m.alloc_id_o[k]), 32'(x));
        end
        if (fl) begin
            m_reset();
        end else begin
            acc0  = fv[0] && f0 >= 0 && f0 < 8 && m_inuse[f0];
            acc1  = fv[1] && f1 >= 0 && f1 < 8 && m_inuse[f1] && !(acc0 && f0 == f1);
            m_err = (fv[0] && !acc0) || (fv[1] && !acc1);
            for (int k = 0; k < nal; k++) begin
                m_inuse[m_q[0]] = 1'b1;
                void'(m_q.pop_front());
            end
            if (acc0) begin m_q.push_back(f0); m_inuse[f0] = 1'b0; end
            if (acc1) begin m_q.push_back(f1); m_inuse[f1] = 1'b0; end
        end
        tick();
        bus_m.alloc_ready_i = 2'b00;
        bus_m.free_valid_i  = 2'b00;
        flush_m             = 1'b0;
    endtask

    initial begin
        int x;
        rst     = 1'b1;
        flush_m = 1'b0;
        flush_h = 1'b0;
        flush_p = 1'b0;
        bus_m.alloc_ready_i = 2'b00; bus_m.free_valid_i = 2'b00; bus_m.free_id_i = '0;
        bus_h.alloc_ready_i = 2'b00; bus_h.free_valid_i = 1'b0;  bus_h.free_id_i = '0;
        bus_p.alloc_ready_i = 1'b0;  bus_p.free_valid_i = 1'b0;  bus_p.free_id_i = '0;
        m_reset();
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        chk("rst_id0", 32'(bus_m.alloc_id_o[0]), 32'd0);
        chk("rst_id1", 32'(bus_m.alloc_id_o[1]), 32'd1);
        chk("rst_valid", 32'(bus_m.alloc_valid_o), 32'd3);
        chk("rst_usage", 32'(bus_m.usage_o), 32'd8);
        chk("rst_full", 32'(bus_m.full_o), 32'd1);
        chk("rst_p_usage", 32'(bus_p.usage_o), 32'd6);

        // Drain in order.
        repeat (4) step(2'b11, 2'b00, 0, 0, 1'b0);
        chk("drain_empty", 32'(bus_m.empty_o), 32'd1);
        chk("drain_valid", 32'(bus_m.alloc_valid_o), 32'd0);
        step(2'b11, 2'b00, 0, 0, 1'b0);

        // Prefix rule.
        step(2'b00, 2'b00, 0, 0, 1'b1);
        step(2'b10, 2'b00, 0, 0, 1'b0);
        chk("prefix_gap", 32'(bus_m.usage_o), 32'd8);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        chk("prefix_take", 32'(bus_m.usage_o), 32'd6);

        // Wrap-around.
        step(2'b00, 2'b00, 0, 0, 1'b1);
        repeat (4) step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 5, 2, 1'b0);
        chk("wrap_usage", 32'(bus_m.usage_o), 32'd2);
        chk("wrap_id0", 32'(bus_m.alloc_id_o[0]), 32'd5);
        chk("wrap_id1", 32'(bus_m.alloc_id_o[1]), 32'd2);
        for (int i = 0; i < 20; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0);
        end

        // Errors.
        step(2'b00, 2'b00, 0, 0, 1'b1);
        step(2'b00, 2'b01, 3, 0, 1'b0);
        chk("err_free_pulse", 32'(bus_m.free_err_o), 32'd1);
        chk("err_free_usage", 32'(bus_m.usage_o), 32'd8);
        step(2'b00, 2'b00, 0, 0, 1'b0);
        chk("err_single", 32'(bus_m.free_err_o), 32'd0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b00, 2'b11, 4, 4, 1'b0);
        chk("dup_usage", 32'(bus_m.usage_o), 32'd4);
        chk("dup_err", 32'(bus_m.free_err_o), 32'd1);
        step(2'b00, 2'b00, 0, 0, 1'b1);
        step(2'b01, 2'b01, 0, 0, 1'b0);
        chk("same_cycle_err", 32'(bus_m.free_err_o), 32'd1);
        chk("same_cycle_usage", 32'(bus_m.usage_o), 32'd7);

        // Flush overrides same-cycle handshakes.
        step(2'b00, 2'b00, 0, 0, 1'b1);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b00, 0, 0, 1'b0);
        step(2'b01, 2'b00, 0, 0, 1'b0);
        step(2'b11, 2'b11, 0, 1, 1'b1);
        chk("flush_usage", 32'(bus_m.usage_o), 32'd8);
        chk("flush_id0", 32'(bus_m.alloc_id_o[0]), 32'd0);
        chk("flush_id1", 32'(bus_m.alloc_id_o[1]), 32'd1);
        chk("flush_valid", 32'(bus_m.alloc_valid_o), 32'd3);
        chk("flush_full", 32'(bus_m.full_o), 32'd1);
        chk("flush_empty", 32'(bus_m.empty_o), 32'd0);
        chk("flush_err", 32'(bus_m.free_err_o), 32'd0);
        step(2'b00, 2'b00, 0, 0, 1'b0);

        // One-hot encoding.
        chk("oh_id0", 32'(bus_h.alloc_id_o[0]), 32'h01);
        chk("oh_id1", 32'(bus_h.alloc_id_o[1]), 32'h02);
        bus_h.alloc_ready_i = 2'b01;
        tick();
        bus_h.alloc_ready_i = 2'b00;
        chk("oh_alloc_usage", 32'(bus_h.usage_o), 32'd7);
        chk("oh_alloc_id0", 32'(bus_h.alloc_id_o[0]), 32'h02);
        bus_h.free_valid_i = 1'b1;
        bus_h.free_id_i[0] = 8'h06;
        tick();
        chk("oh_twobit_err", 32'(bus_h.free_err_o), 32'd1);
        chk("oh_twobit_usage", 32'(bus_h.usage_o), 32'd7);
        bus_h.free_id_i[0] = 8'h01;
        tick();
        bus_h.free_valid_i = 1'b0;
        chk("oh_free_err", 32'(bus_h.free_err_o), 32'd0);
        chk("oh_free_usage", 32'(bus_h.usage_o), 32'd8);

        // Non-power-of-two pool: out-of-range frees and pointer wrap.
        bus_p.free_valid_i = 1'b1;
        bus_p.free_id_i[0] = 3'd6;
        tick();
        chk("p_free6_err", 32'(bus_p.free_err_o), 32'd1);
        bus_p.free_id_i[0] = 3'd7;
        tick();
        chk("p_free7_err", 32'(bus_p.free_err_o), 32'd1);
        chk("p_free7_usage", 32'(bus_p.usage_o), 32'd6);
        bus_p.free_valid_i = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(i % 6);
            bus_p.alloc_ready_i = 1'b1;
            bus_p.free_valid_i  = (i > 0);
            bus_p.free_id_i[0]  = (i > 0) ? 3'((i - 1) % 6) : 3'd0;
            x = exp_q.pop_front();
            chk("p_wrap_id", 32'(bus_p.alloc_id_o[0]), 32'(x));
            chk("p_wrap_usage", 32'(bus_p.usage_o), (i == 0) ? 32'd6 : 32'd5);
            tick();
            chk("p_wrap_err", 32'(bus_p.free_err_o), 32'd0);
        end
        bus_p.alloc_ready_i = 1'b0;
        bus_p.free_valid_i  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
